// File: rtl/ifetch_queue_pkg.sv
// ----------------------------------------------------------------------------
// ifetch_queue_pkg
// Shared types for the instruction fetch queue:
//   word_t       32-bit machine word (PCs and instruction words)
//   ifq_entry_t  one buffered fetch result {pc, instr}
//   ifq_state_t  fetch handshake state (idle / waiting for data / dropping)
// ----------------------------------------------------------------------------
package ifetch_queue_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t pc;
        word_t instr;
    } ifq_entry_t;

    typedef enum logic [1:0] {
        IFQ_IDLE = 2'd0,
        IFQ_WAIT = 2'd1,
        IFQ_DROP = 2'd2
    } ifq_state_t;

    localparam word_t WORD_ZERO = 32'h0000_0000;

    function automatic ifq_entry_t ifq_make_entry(input word_t pc, input word_t instr);
        ifq_entry_t e;
        e.pc    = pc;
        e.instr = instr;
        return e;
    endfunction

endpackage

// File: rtl/ifetch_queue_chk.sv
// ----------------------------------------------------------------------------
// ifetch_queue_chk
// Structural invariants of the fetch queue, kept apart from the datapath.
// Ports:
//   clk, resetn  clock and asynchronous active-low reset
//   wr_en        a word is being written into storage this cycle
//   full         storage is full
//   state        fetch handshake state
// ----------------------------------------------------------------------------
module ifetch_queue_chk
    import ifetch_queue_pkg::*;
(
    input logic       clk,
    input logic       resetn,
    input logic       wr_en,
    input logic       full,
    input ifq_state_t state
);

    // Writing into a full buffer would overwrite the oldest unread word.
    a_no_enq_when_full: assert property (@(posedge clk) disable iff (!resetn)
        !(wr_en && full));

    // The state register only ever holds one of the three encoded states.
    a_state_legal: assert property (@(posedge clk) disable iff (!resetn)
        (state inside {IFQ_IDLE, IFQ_WAIT, IFQ_DROP}));

endmodule

// File: rtl/ifq_ram.sv
// ----------------------------------------------------------------------------
// ifq_ram
// DEPTH-entry storage for the fetch queue. One synchronous write port and one
// combinational read port. The array carries no reset: an entry is only ever
// read after it has been written, because the pointers gate validity.
// Ports:
//   clk    clock
//   we     write enable
//   waddr  write index
//   wdata  entry to store
//   raddr  read index (queue head)
//   rdata  entry at raddr
// ----------------------------------------------------------------------------
module ifq_ram
    import ifetch_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  ifq_entry_t       wdata,
    input  logic [PTR_W-1:0] raddr,
    output ifq_entry_t       rdata
);

    ifq_entry_t mem_q [DEPTH];

    // Write port: capture the entry at the tail index.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/ifetch_queue.sv
// ----------------------------------------------------------------------------
// ifetch_queue
// Instruction fetch queue between the instruction memory handshake and the
// fetch/decode register. Tracks one outstanding fetch, buffers each returned
// word together with its PC, and presents them in order downstream. A flush
// empties the buffer and discards a response that is still in flight.
//
// Optional feature: define IFETCH_QUEUE_BYPASS_EN to forward a returning word
// straight to the deq_* outputs in the same cycle when the buffer is empty.
//
// Ports:
//   clk, resetn             clock, asynchronous active-low reset
//   flush                   redirect/exception flush
//   fetch_req, fetch_pc     fetch issue (only when fetch_ready=1)
//   fetch_ready             a fetch may be issued this cycle
//   i_data_ok, instr_       returned instruction word from memory
//   deq_valid/pc/instr      head entry presented downstream
//   deq_ready               downstream consumes the head this cycle
//   count                   number of buffered entries
// ----------------------------------------------------------------------------
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          flush,
    input  logic          fetch_req,
    input  logic [31:0]   fetch_pc,
    output logic          fetch_ready,
    input  logic          i_data_ok,
    input  logic [31:0]   instr_,
    output logic          deq_valid,
    output logic [31:0]   deq_pc,
    output logic [31:0]   deq_instr,
    input  logic          deq_ready,
    output logic [PTR_W:0] count
);

    localparam logic [PTR_W:0] PTR_ZERO   = {(PTR_W+1){1'b0}};
    localparam logic [PTR_W:0] PTR_ONE    = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] DEPTH_C    = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] DEPTH_M1_C = (PTR_W+1)'(DEPTH - 1);

    ifq_state_t     state_q, state_d;
    word_t          pend_pc_q, pend_pc_d;
    logic [PTR_W:0] head_q, head_d;
    logic [PTR_W:0] tail_q, tail_d;

    logic           empty_s;
    logic           full_s;
    logic [PTR_W:0] count_s;
    logic           fetch_fire_s;
    logic           enq_s;
    logic           wr_en_s;
    logic           deq_fire_s;
    logic           bypass_s;
    ifq_entry_t     wr_entry_s;
    ifq_entry_t     rd_entry_s;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty_s = (head_q == tail_q);
    assign full_s  = (head_q[PTR_W-1:0] == tail_q[PTR_W-1:0]) &&
                     (head_q[PTR_W] != tail_q[PTR_W]);
    assign count_s = tail_q - head_q;
    assign count   = count_s;

    // Fetch admission: a new fetch is allowed only if its eventual word has a
    // slot reserved, so an enqueue can never land on a full buffer.
    always_comb begin
        fetch_ready = 1'b0;
        if (flush) begin
            fetch_ready = 1'b0;
        end else begin
            case (state_q)
                IFQ_IDLE: fetch_ready = (count_s < DEPTH_C);
                // Back-to-back issue: the word returning now takes one slot.
                IFQ_WAIT: fetch_ready = i_data_ok && (count_s < DEPTH_M1_C);
                IFQ_DROP: fetch_ready = 1'b0;
                default:  fetch_ready = 1'b0;
            endcase
        end
    end

    assign fetch_fire_s = fetch_req && fetch_ready;
    assign enq_s        = (state_q == IFQ_WAIT) && i_data_ok && !flush;
    assign deq_fire_s   = !empty_s && deq_ready && !flush;

`ifdef IFETCH_QUEUE_BYPASS_EN
    assign bypass_s = empty_s && enq_s;
`else
    assign bypass_s = 1'b0;
`endif

    // A bypassed word that is consumed immediately never touches storage.
    assign wr_en_s    = enq_s && !(bypass_s && deq_ready);
    assign wr_entry_s = ifq_make_entry(pend_pc_q, instr_);

    ifq_ram #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en_s),
        .waddr (tail_q[PTR_W-1:0]),
        .wdata (wr_entry_s),
        .raddr (head_q[PTR_W-1:0]),
        .rdata (rd_entry_s)
    );

    // Downstream view: bypassed word, else buffered head, else zeros.
    always_comb begin
        deq_valid = 1'b0;
        deq_pc    = WORD_ZERO;
        deq_instr = WORD_ZERO;
        if (bypass_s) begin
            deq_valid = 1'b1;
            deq_pc    = pend_pc_q;
            deq_instr = instr_;
        end else if (!empty_s) begin
            deq_valid = 1'b1;
            deq_pc    = rd_entry_s.pc;
            deq_instr = rd_entry_s.instr;
        end else begin
            deq_valid = 1'b0;
        end
    end

    // Fetch handshake next state and pending PC.
    always_comb begin
        state_d   = state_q;
        pend_pc_d = pend_pc_q;
        case (state_q)
            IFQ_IDLE: begin
                if (fetch_fire_s) begin
                    state_d   = IFQ_WAIT;
                    pend_pc_d = fetch_pc;
                end else begin
                    state_d   = IFQ_IDLE;
                end
            end
            IFQ_WAIT: begin
                if (flush) begin
                    // Without the data in hand the response is still owed and
                    // must be swallowed when it arrives.
                    state_d = i_data_ok ? IFQ_IDLE : IFQ_DROP;
                end else if (i_data_ok) begin
                    if (fetch_fire_s) begin
                        state_d   = IFQ_WAIT;
                        pend_pc_d = fetch_pc;
                    end else begin
                        state_d   = IFQ_IDLE;
                    end
                end else begin
                    state_d = IFQ_WAIT;
                end
            end
            IFQ_DROP: begin
                if (i_data_ok) begin
                    state_d = IFQ_IDLE;
                end else begin
                    state_d = IFQ_DROP;
                end
            end
            default: begin
                state_d = IFQ_IDLE;
            end
        endcase
    end

    // Pointer update; a flush overrides any same-cycle enqueue or dequeue.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (flush) begin
            head_d = PTR_ZERO;
            tail_d = PTR_ZERO;
        end else begin
            head_d = head_q + (deq_fire_s ? PTR_ONE : PTR_ZERO);
            tail_d = tail_q + (wr_en_s ? PTR_ONE : PTR_ZERO);
        end
    end

    // State, pending PC and pointer registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IFQ_IDLE;
            pend_pc_q <= WORD_ZERO;
            head_q    <= PTR_ZERO;
            tail_q    <= PTR_ZERO;
        end else begin
            state_q   <= state_d;
            pend_pc_q <= pend_pc_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
        end
    end

    ifetch_queue_chk u_chk (
        .clk    (clk),
        .resetn (resetn),
        .wr_en  (wr_en_s),
        .full   (full_s),
        .state  (state_q)
    );

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;

    localparam int DEPTH = 8;
`ifdef IFETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic        fetch_req;
    logic [31:0] fetch_pc;
    logic        fetch_ready;
    logic        i_data_ok;
    logic [31:0] instr_;
    logic        deq_valid;
    logic [31:0] deq_pc;
    logic [31:0] deq_instr;
    logic        deq_ready;
    logic [3:0]  count;

    int errors = 0;
    int checks = 0;

    // Reference model: buffered {pc, instr} words in order, one owed response
    // (m_out) or one response to be discarded (m_stale).
    logic [63:0] mq[$];
    bit          m_out;
    bit          m_stale;
    logic [31:0] m_pc;

    always #5 clk = ~clk;

    ifetch_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .flush       (flush),
        .fetch_req   (fetch_req),
        .fetch_pc    (fetch_pc),
        .fetch_ready (fetch_ready),
        .i_data_ok   (i_data_ok),
        .instr_      (instr_),
        .deq_valid   (deq_valid),
        .deq_pc      (deq_pc),
        .deq_instr   (deq_instr),
        .deq_ready   (deq_ready),
        .count       (count)
    );

    function automatic logic [31:0] ins_of(input logic [31:0] pc);
        return pc ^ 32'h5A5A_0000;
    endfunction

    function automatic bit exp_ready();
        if (flush || m_stale) return 1'b0;
        if (m_out) return i_data_ok && (mq.size() + 1 < DEPTH);
        return mq.size() < DEPTH;
    endfunction

    function automatic bit exp_bypass();
        return BYP && (mq.size() == 0) && m_out && i_data_ok && !flush;
    endfunction

    function automatic bit exp_valid();
        return (mq.size() != 0) || exp_bypass();
    endfunction

    function automatic logic [31:0] exp_pc();
        if (mq.size() != 0) return mq[0][63:32];
        if (exp_bypass()) return m_pc;
        return 32'h0;
    endfunction

    function automatic logic [31:0] exp_instr();
        if (mq.size() != 0) return mq[0][31:0];
        if (exp_bypass()) return instr_;
        return 32'h0;
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_edge();
        bit had  = (mq.size() != 0);
        bit byp  = exp_bypass();
        bit fire = fetch_req && exp_ready();
        if (!resetn) begin
            mq.delete(); m_out = 1'b0; m_stale = 1'b0; m_pc = 32'h0;
        end else if (flush) begin
            mq.delete();
            if (m_out && !i_data_ok) m_stale = 1'b1;
            else if (m_stale && i_data_ok) m_stale = 1'b0;
            m_out = 1'b0;
        end else begin
            if (deq_ready && had) void'(mq.pop_front());
            if (m_stale) begin
                if (i_data_ok) m_stale = 1'b0;
            end else begin
                if (m_out && i_data_ok) begin
                    if (!(byp && deq_ready)) mq.push_back({m_pc, instr_});
                    m_out = 1'b0;
                end
                if (fire) begin
                    m_out = 1'b1;
                    m_pc  = fetch_pc;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic f, input logic rq, input logic [31:0] pc,
                         input logic ok, input logic [31:0] ins, input logic rdy);
        flush = f; fetch_req = rq; fetch_pc = pc;
        i_data_ok = ok; instr_ = ins; deq_ready = rdy;
        #2;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick(); tick();
        checks++; if (deq_valid !== 1'b0) begin errors++; $display("FAIL reset_deq_valid: got %b want 0", deq_valid); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (deq_pc !== 32'h0 || deq_instr !== 32'h0) begin errors++; $display("FAIL reset_deq_data: got %h/%h want 0/0", deq_pc, deq_instr); end
        checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL reset_fetch_ready: got %b want 1", fetch_ready); end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        drive(1'b0, 1'b1, 32'hBFC0_0000, 1'b0, 32'h0, 1'b0);
        checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b want 1", fetch_ready); end
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h2408_0001, 1'b0);
        checks++; if (deq_valid !== BYP) begin errors++; $display("FAIL basic_same_cycle_valid: got %b want %b", deq_valid, BYP); end
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks++; if (deq_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", deq_valid); end
        checks++; if (deq_pc !== 32'hBFC0_0000) begin errors++; $display("FAIL basic_pc: got %h want bfc00000", deq_pc); end
        checks++; if (deq_instr !== 32'h2408_0001) begin errors++; $display("FAIL basic_instr: got %h want 24080001", deq_instr); end
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL basic_count: got %0d want 1", count); end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks++; if (count !== 4'd0 || deq_valid !== 1'b0) begin errors++; $display("FAIL basic_drained: got count=%0d valid=%b want 0/0", count, deq_valid); end
    endtask

    task automatic test_fill_wrap();
        drive(1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
        tick();
        for (int k = 1; k < 8; k++) begin
            drive(1'b0, 1'b1, 32'h100 + 32'(4 * k), 1'b1, ins_of(32'h100 + 32'(4 * (k - 1))), 1'b0);
            checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d: got %b want 1", k, fetch_ready); end
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1, ins_of(32'h11C), 1'b0);
        checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL fill_last_ready: got %b want 0", fetch_ready); end
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL fill_count: got %0d want 8", count); end
        checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready: got %b want 0", fetch_ready); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
            checks++; if (deq_pc !== 32'h100 + 32'(4 * i)) begin errors++; $display("FAIL drain3_pc_%0d: got %h want %h", i, deq_pc, 32'h100 + 32'(4 * i)); end
            tick();
        end
        drive(1'b0, 1'b1, 32'h120, 1'b0, 32'h0, 1'b0); tick();
        drive(1'b0, 1'b1, 32'h124, 1'b1, ins_of(32'h120), 1'b0); tick();
        drive(1'b0, 1'b1, 32'h128, 1'b1, ins_of(32'h124), 1'b0); tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1, ins_of(32'h128), 1'b0); tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL wrap_count: got %0d want 8", count); end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
            checks++;
            if (deq_valid !== 1'b1 || deq_pc !== 32'h10C + 32'(4 * i) || deq_instr !== ins_of(32'h10C + 32'(4 * i))) begin
                errors++;
                $display("FAIL wrap_order_%0d: got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h", i, deq_valid, deq_pc, deq_instr,
                         32'h10C + 32'(4 * i), ins_of(32'h10C + 32'(4 * i)));
            end
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL wrap_empty: got %0d want 0", count); end
    endtask

    task automatic test_flush_wait();
        drive(1'b0, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0); tick();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL flushw_ready_flush: got %b want 0", fetch_ready); end
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL flushw_ready_drop: got %b want 0", fetch_ready); end
        checks++; if (deq_valid !== 1'b0) begin errors++; $display("FAIL flushw_drop_valid: got %b want 0", deq_valid); end
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks++; if (count !== 4'd0 || deq_valid !== 1'b0 || fetch_ready !== 1'b1) begin
            errors++; $display("FAIL flushw_after: got count=%0d valid=%b ready=%b want 0/0/1", count, deq_valid, fetch_ready);
        end
    endtask

    task automatic test_flush_coincident();
        drive(1'b0, 1'b1, 32'h400, 1'b0, 32'h0, 1'b0); tick();
        drive(1'b0, 1'b1, 32'h404, 1'b1, ins_of(32'h400), 1'b0); tick();
        drive(1'b0, 1'b1, 32'h408, 1'b1, ins_of(32'h404), 1'b0); tick();
        drive(1'b1, 1'b0, 32'h0, 1'b1, ins_of(32'h408), 1'b0);
        checks++; if (count !== 4'd2) begin errors++; $display("FAIL flushc_before: got %0d want 2", count); end
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks++; if (count !== 4'd0 || deq_valid !== 1'b0 || fetch_ready !== 1'b1) begin
            errors++; $display("FAIL flushc_after: got count=%0d valid=%b ready=%b want 0/0/1", count, deq_valid, fetch_ready);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 1'b1, 32'h500, 1'b0, 32'h0, 1'b0); tick();
        for (int k = 1; k <= 3; k++) begin
            drive(1'b0, 1'b1, 32'h500 + 32'(4 * k), 1'b1, ins_of(32'h500 + 32'(4 * (k - 1))), 1'b0);
            tick();
        end
        for (int s = 0; s < 20; s++) begin
            drive(1'b0, 1'b1, 32'h500 + 32'(4 * (s + 4)), 1'b1, ins_of(32'h500 + 32'(4 * (s + 3))), 1'b1);
            checks++;
            if (count !== 4'd3 || deq_pc !== 32'h500 + 32'(4 * s) || fetch_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_%0d: got count=%0d pc=%h ready=%b want 3 pc=%h ready=1", s, count, deq_pc, fetch_ready, 32'h500 + 32'(4 * s));
            end
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks++; if (count !== 4'd3 || deq_pc !== 32'h550) begin errors++; $display("FAIL stream_end: got count=%0d pc=%h want 3 pc=00000550", count, deq_pc); end
        drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0); tick();
    endtask

    task automatic test_bypass();
        drive(1'b0, 1'b1, 32'h300, 1'b0, 32'h0, 1'b1); tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h3C1D_0300, 1'b1);
        checks++;
        if (deq_valid !== BYP || deq_pc !== (BYP ? 32'h300 : 32'h0) || deq_instr !== (BYP ? 32'h3C1D_0300 : 32'h0)) begin
            errors++; $display("FAIL bypass_same: got v=%b pc=%h ins=%h want v=%b", deq_valid, deq_pc, deq_instr, BYP);
        end
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checks++;
        if (count !== (BYP ? 4'd0 : 4'd1) || deq_valid !== !BYP || deq_pc !== (BYP ? 32'h0 : 32'h300)) begin
            errors++; $display("FAIL bypass_next: got count=%0d v=%b pc=%h want v=%b", count, deq_valid, deq_pc, !BYP);
        end
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL bypass_empty: got %0d want 0", count); end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b1, 32'h600, 1'b0, 32'h0, 1'b0); tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1, ins_of(32'h600), 1'b0); tick();
        drive(1'b0, 1'b1, 32'h604, 1'b0, 32'h0, 1'b0); tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL midrst_before: got %0d want 1", count); end
        resetn = 1'b0;
        #1;
        checks++; if (count !== 4'd0 || deq_valid !== 1'b0 || fetch_ready !== 1'b1) begin
            errors++; $display("FAIL midrst_async: got count=%0d valid=%b ready=%b want 0/0/1", count, deq_valid, fetch_ready);
        end
        mq.delete(); m_out = 1'b0; m_stale = 1'b0; m_pc = 32'h0;
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            flush     = ($urandom_range(0, 24) == 0);
            i_data_ok = (m_out || m_stale) && ($urandom_range(0, 2) != 0);
            deq_ready = ($urandom_range(0, 99) < (((c / 150) % 2 == 1) ? 85 : 20));
            instr_    = $urandom();
            fetch_pc  = $urandom() & 32'hFFFF_FFFC;
            fetch_req = 1'b0;
            #1;
            fetch_req = exp_ready() && ($urandom_range(0, 3) != 0);
            #1;
            checks++;
            if (fetch_ready !== exp_ready() || deq_valid !== exp_valid() || count !== 4'(mq.size()) ||
                deq_pc !== exp_pc() || deq_instr !== exp_instr()) begin
                errors++;
                $display("FAIL random_%0d: got rdy=%b v=%b cnt=%0d pc=%h ins=%h want rdy=%b v=%b cnt=%0d pc=%h ins=%h",
                         c, fetch_ready, deq_valid, count, deq_pc, deq_instr,
                         exp_ready(), exp_valid(), mq.size(), exp_pc(), exp_instr());
            end
            tick();
        end
    endtask

    initial begin
        mq.delete(); m_out = 1'b0; m_stale = 1'b0; m_pc = 32'h0;
        test_reset();
        test_basic();
        test_fill_wrap();
        test_flush_wait();
        test_flush_coincident();
        test_back_to_back();
        test_bypass();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
